pop_req_sequencer: RTL and testbench

//  Upstream front end of the pop RPU pair. Accepts dequeue requests from the scheduler (valid/ready),

---
 rtl/pop_req_sequencer_pkg.sv | 20 ++
 rtl/pop_req_sequencer_if.sv | 28 ++
 rtl/pop_req_sequencer_rsp_fifo.sv | 48 ++++
 rtl/pop_req_sequencer.sv | 133 +++++++++++++
 tb/tb_pop_req_sequencer.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pop_req_sequencer_pkg.sv
// Shared types and helpers for the pop request sequencer and its response FIFO.
package pop_req_sequencer_pkg;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } seq_state_t;

   localparam int DEF_PTW     = 16;
   localparam int DEF_MTW     = 0;
   localparam int DEF_OCW     = 12;
   localparam int DEF_POP_LAT = 2;
   localparam int DEF_RQD     = 4;

   // Width of a down-counter that must hold values 0..lat-1.
   function automatic int lat_w(input int lat);
      return (lat <= 2) ? 1 : $clog2(lat);
   endfunction

endpackage

// File: rtl/pop_req_sequencer_if.sv
// Scheduler request/response, push-path notify and RPU-pair pop signals of the sequencer.
interface pop_req_sequencer_if #(
   parameter int DW  = 16,
   parameter int OCW = 12
);
   logic           i_deq_valid;
   logic           o_deq_ready;
   logic           o_rsp_valid;
   logic           i_rsp_ready;
   logic [DW-1:0]  o_rsp_data;
   logic           o_rsp_empty;
   logic           i_push_done;
   logic           o_pop;
   logic           i_pair_ready;
   logic [DW-1:0]  i_pop_data;
   logic [OCW-1:0] o_occupancy;
   logic           o_ovf;

   modport slave (
      input  i_deq_valid, i_rsp_ready, i_push_done, i_pair_ready, i_pop_data,
      output o_deq_ready, o_rsp_valid, o_rsp_data, o_rsp_empty, o_pop, o_occupancy, o_ovf
   );

   modport master (
      output i_deq_valid, i_rsp_ready, i_push_done, i_pair_ready, i_pop_data,
      input  o_deq_ready, o_rsp_valid, o_rsp_data, o_rsp_empty, o_pop, o_occupancy, o_ovf
   );
endinterface

// File: rtl/pop_req_sequencer_rsp_fifo.sv
// First-word-fall-through response FIFO; pointers carry an extra wrap bit for full/empty.
module pop_rsp_fifo #(
   parameter int W     = 17,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH),
   localparam int PW   = AW + 1
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          wr_en_i,
   input  logic [W-1:0]  wr_data_i,
   input  logic          rd_en_i,
   output logic [W-1:0]  rd_data_o,
   output logic          empty_o,
   output logic [AW:0]   count_o
);

   logic [DEPTH-1:0][W-1:0] mem_q;
   logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
   logic                    rd_fire;

   assign empty_o   = (wr_ptr_q == rd_ptr_q);
   assign count_o   = wr_ptr_q - rd_ptr_q;
   assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];
   assign rd_fire   = rd_en_i && !empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (wr_en_i) wr_ptr_d = wr_ptr_q + PW'(1);
      if (rd_fire) rd_ptr_d = rd_ptr_q + PW'(1);
   end

   // The writer never targets a full FIFO, so write and read never share a slot.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mem_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (wr_en_i) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

endmodule

// File: rtl/pop_req_sequencer.sv
// Front end of the pop RPU pair: accepts dequeue requests, tracks tree occupancy,
// issues single-cycle pops and buffers popped elements for the response port.
module pop_req_sequencer
   import pop_req_sequencer_pkg::*;
#(
   parameter int PTW     = DEF_PTW,
   parameter int MTW     = DEF_MTW,
   parameter int OCW     = DEF_OCW,
   parameter int POP_LAT = DEF_POP_LAT,
   parameter int RQD     = DEF_RQD
) (
   input  logic                 i_clk,
   input  logic                 i_arst_n,
   pop_req_sequencer_if.slave   bus_io
);

   localparam int DW = MTW + PTW;
   localparam int AW = $clog2(RQD);
   localparam int LW = lat_w(POP_LAT);

   typedef struct packed {
      logic          empty;
      logic [DW-1:0] data;
   } rsp_t;

   seq_state_t     state_q, state_d;
   logic [LW-1:0]  lat_q, lat_d;
   logic [OCW-1:0] occ_q, occ_d;
   logic           ovf_q, ovf_d;

   logic           credit;
   logic           deq_ready;
   logic           accept;
   logic           pop_fire;
   logic           fifo_wr;
   logic           fifo_empty;
   logic [AW:0]    fifo_cnt;
   rsp_t           wr_rsp;
   rsp_t           rd_rsp;

   // An in-flight pop already owns one FIFO slot.
   assign credit    = (32'(fifo_cnt) + 32'(state_q != ST_IDLE)) < 32'(RQD);
   assign deq_ready = (state_q == ST_IDLE) && bus_io.i_pair_ready && credit;
   assign accept    = bus_io.i_deq_valid && deq_ready;

   always_comb begin
      state_d      = state_q;
      lat_d        = lat_q;
      pop_fire     = 1'b0;
      fifo_wr      = 1'b0;
      wr_rsp.empty = 1'b0;
      wr_rsp.data  = bus_io.i_pop_data;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (occ_q == '0) begin
                  fifo_wr      = 1'b1;
                  wr_rsp.empty = 1'b1;
                  wr_rsp.data  = '1;
               end else begin
                  pop_fire = 1'b1;
                  lat_d    = LW'(POP_LAT - 1);
                  state_d  = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (lat_q == '0) begin
               fifo_wr = 1'b1;
               state_d = ST_IDLE;
            end else begin
               lat_d = lat_q - LW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         state_q <= ST_IDLE;
         lat_q   <= '0;
      end else begin
         state_q <= state_d;
         lat_q   <= lat_d;
      end
   end

   // Push and pop in the same cycle cancel; a push at the ceiling is dropped and flagged.
   always_comb begin
      occ_d = occ_q;
      ovf_d = ovf_q;
      if (bus_io.i_push_done && !pop_fire) begin
         if (occ_q == '1) ovf_d = 1'b1;
         else             occ_d = occ_q + OCW'(1);
      end else if (pop_fire && !bus_io.i_push_done) begin
         occ_d = occ_q - OCW'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         occ_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         occ_q <= occ_d;
         ovf_q <= ovf_d;
      end
   end

   pop_rsp_fifo #(
      .W     ($bits(rsp_t)),
      .DEPTH (RQD)
   ) u_rsp_fifo (
      .clk_i     (i_clk),
      .rst_ni    (i_arst_n),
      .wr_en_i   (fifo_wr),
      .wr_data_i (wr_rsp),
      .rd_en_i   (bus_io.i_rsp_ready),
      .rd_data_o (rd_rsp),
      .empty_o   (fifo_empty),
      .count_o   (fifo_cnt)
   );

   assign bus_io.o_deq_ready = deq_ready;
   assign bus_io.o_pop       = pop_fire;
   assign bus_io.o_rsp_valid = !fifo_empty;
   assign bus_io.o_rsp_data  = rd_rsp.data;
   assign bus_io.o_rsp_empty = rd_rsp.empty;
   assign bus_io.o_occupancy = occ_q;
   assign bus_io.o_ovf       = ovf_q;

endmodule

// File: tb/tb_pop_req_sequencer.sv
// Directed scenarios plus a randomized run against a timestamp/queue reference model.
`timescale 1ns/1ps
module tb_pop_req_sequencer;

   localparam int DW      = 16;
   localparam int OCW     = 12;
   localparam int POP_LAT = 2;
   localparam int RQD     = 4;
   localparam int OCC_MAX = (1 << OCW) - 1;

   logic clk    = 1'b0;
   logic arst_n = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   pop_req_sequencer_if #(.DW(DW), .OCW(OCW)) bus();

   pop_req_sequencer #(
      .PTW(16), .MTW(0), .OCW(OCW), .POP_LAT(POP_LAT), .RQD(RQD)
   ) dut (
      .i_clk    (clk),
      .i_arst_n (arst_n),
      .bus_io   (bus)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      bus.i_deq_valid  = 1'b0;
      bus.i_rsp_ready  = 1'b0;
      bus.i_push_done  = 1'b0;
      bus.i_pair_ready = 1'b0;
      bus.i_pop_data   = '0;
   endtask

   task automatic apply_reset();
      idle_inputs();
      @(negedge clk);
      arst_n = 1'b0;
      step();
      step();
      arst_n = 1'b1;
      step();
   endtask

   task automatic push_n(input int n);
      for (int i = 0; i < n; i++) begin
         bus.i_push_done = 1'b1;
         step();
      end
      bus.i_push_done = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      #2 arst_n = 1'b0;
      @(negedge clk); #1;
      n_tests++; if (bus.o_deq_ready !== 1'b0) begin n_fail++; $display("FAIL reset_deq_ready got %0b want 0", bus.o_deq_ready); end
      n_tests++; if (bus.o_pop !== 1'b0) begin n_fail++; $display("FAIL reset_pop got %0b want 0", bus.o_pop); end
      n_tests++; if (bus.o_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %0b want 0", bus.o_rsp_valid); end
      n_tests++; if (bus.o_rsp_data !== 16'h0) begin n_fail++; $display("FAIL reset_rsp_data got %0h want 0", bus.o_rsp_data); end
      n_tests++; if (bus.o_rsp_empty !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_empty got %0b want 0", bus.o_rsp_empty); end
      n_tests++; if (bus.o_occupancy !== 12'h0) begin n_fail++; $display("FAIL reset_occ got %0h want 0", bus.o_occupancy); end
      n_tests++; if (bus.o_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %0b want 0", bus.o_ovf); end
      arst_n = 1'b1;
      step();
   endtask

   task automatic test_basic_pop();
      apply_reset();
      bus.i_pair_ready = 1'b1;
      bus.i_rsp_ready  = 1'b1;
      push_n(3);
      #1;
      n_tests++; if (bus.o_occupancy !== 12'd3) begin n_fail++; $display("FAIL basic_occ3 got %0d want 3", bus.o_occupancy); end
      bus.i_deq_valid = 1'b1; bus.i_pop_data = 16'h1234; #1;
      n_tests++; if (bus.o_pop !== 1'b1) begin n_fail++; $display("FAIL basic_pop_T got %0b want 1", bus.o_pop); end
      step();
      bus.i_deq_valid = 1'b0; bus.i_pop_data = 16'h5678; #1;
      n_tests++; if (bus.o_pop !== 1'b0) begin n_fail++; $display("FAIL basic_pop_T1 got %0b want 0", bus.o_pop); end
      n_tests++; if (bus.o_deq_ready !== 1'b0) begin n_fail++; $display("FAIL basic_ready_wait got %0b want 0", bus.o_deq_ready); end
      n_tests++; if (bus.o_occupancy !== 12'd2) begin n_fail++; $display("FAIL basic_occ2 got %0d want 2", bus.o_occupancy); end
      step();
      bus.i_pop_data = 16'h00A5; #1;
      n_tests++; if (bus.o_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_T2 got %0b want 0", bus.o_rsp_valid); end
      step();
      bus.i_pop_data = 16'hDEAD; #1;
      n_tests++; if (bus.o_rsp_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid_T3 got %0b want 1", bus.o_rsp_valid); end
      n_tests++; if (bus.o_rsp_data !== 16'h00A5) begin n_fail++; $display("FAIL basic_data got %0h want 00a5", bus.o_rsp_data); end
      n_tests++; if (bus.o_rsp_empty !== 1'b0) begin n_fail++; $display("FAIL basic_empty got %0b want 0", bus.o_rsp_empty); end
      n_tests++; if (bus.o_deq_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready_back got %0b want 1", bus.o_deq_ready); end
      step(); #1;
      n_tests++; if (bus.o_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drained got %0b want 0", bus.o_rsp_valid); end
   endtask

   task automatic test_empty_req();
      apply_reset();
      bus.i_pair_ready = 1'b1;
      bus.i_deq_valid  = 1'b1; #1;
      n_tests++; if (bus.o_deq_ready !== 1'b1) begin n_fail++; $display("FAIL empty_ready got %0b want 1", bus.o_deq_ready); end
      n_tests++; if (bus.o_pop !== 1'b0) begin n_fail++; $display("FAIL empty_no_pop got %0b want 0", bus.o_pop); end
      step();
      bus.i_deq_valid = 1'b0; #1;
      n_tests++; if (bus.o_rsp_valid !== 1'b1) begin n_fail++; $display("FAIL empty_valid got %0b want 1", bus.o_rsp_valid); end
      n_tests++; if (bus.o_rsp_data !== 16'hFFFF) begin n_fail++; $display("FAIL empty_data got %0h want ffff", bus.o_rsp_data); end
      n_tests++; if (bus.o_rsp_empty !== 1'b1) begin n_fail++; $display("FAIL empty_flag got %0b want 1", bus.o_rsp_empty); end
      n_tests++; if (bus.o_occupancy !== 12'd0) begin n_fail++; $display("FAIL empty_occ got %0d want 0", bus.o_occupancy); end
      bus.i_rsp_ready = 1'b1;
      step(); #1;
      n_tests++; if (bus.o_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL empty_consumed got %0b want 0", bus.o_rsp_valid); end
   endtask

   task automatic test_backpressure();
      int acc  = 0;
      int pops = 0;
      int rsps = 0;
      logic [15:0] exp_q[$];
      logic [15:0] exp_d;
      apply_reset();
      bus.i_pair_ready = 1'b1;
      push_n(10);
      #1;
      n_tests++; if (bus.o_occupancy !== 12'd10) begin n_fail++; $display("FAIL bp_occ10 got %0d want 10", bus.o_occupancy); end
      for (int k = 0; k < 80; k++) begin
         bus.i_rsp_ready = (k >= 20);
         bus.i_deq_valid = (acc < 6);
         bus.i_pop_data  = 16'hC000 + 16'(k);
         #1;
         if (k >= 14 && k <= 20) begin
            n_tests++; if (bus.o_deq_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_full k=%0d got %0b want 0", k, bus.o_deq_ready); end
         end
         if (k == 20) begin
            n_tests++; if (pops !== 4) begin n_fail++; $display("FAIL bp_pops_stalled got %0d want 4", pops); end
         end
         if (bus.i_deq_valid && bus.o_deq_ready) acc++;
         if (bus.o_pop) begin
            pops++;
            exp_q.push_back(16'hC000 + 16'(k + POP_LAT));
         end
         if (bus.o_rsp_valid && bus.i_rsp_ready) begin
            rsps++;
            exp_d = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
            n_tests++; if (bus.o_rsp_data !== exp_d || bus.o_rsp_empty !== 1'b0) begin
               n_fail++; $display("FAIL bp_rsp_order #%0d got %0h/%0b want %0h/0", rsps, bus.o_rsp_data, bus.o_rsp_empty, exp_d);
            end
         end
         step();
      end
      #1;
      n_tests++; if (pops !== 6) begin n_fail++; $display("FAIL bp_pops_total got %0d want 6", pops); end
      n_tests++; if (rsps !== 6) begin n_fail++; $display("FAIL bp_rsps_total got %0d want 6", rsps); end
      n_tests++; if (bus.o_occupancy !== 12'd4) begin n_fail++; $display("FAIL bp_occ_end got %0d want 4", bus.o_occupancy); end
   endtask

   task automatic test_pair_stall();
      apply_reset();
      bus.i_rsp_ready = 1'b1;
      push_n(2);
      bus.i_pair_ready = 1'b0;
      bus.i_deq_valid  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         n_tests++; if (bus.o_pop !== 1'b0 || bus.o_deq_ready !== 1'b0) begin
            n_fail++; $display("FAIL stall_cycle%0d got pop=%0b ready=%0b want 0/0", i, bus.o_pop, bus.o_deq_ready);
         end
         step();
      end
      bus.i_pair_ready = 1'b1; #1;
      n_tests++; if (bus.o_pop !== 1'b1) begin n_fail++; $display("FAIL stall_release_pop got %0b want 1", bus.o_pop); end
      step();
      bus.i_deq_valid = 1'b0; #1;
      n_tests++; if (bus.o_occupancy !== 12'd1) begin n_fail++; $display("FAIL stall_occ got %0d want 1", bus.o_occupancy); end
      repeat (4) step();
   endtask

   task automatic test_push_pop_coincide();
      apply_reset();
      bus.i_pair_ready = 1'b1;
      bus.i_rsp_ready  = 1'b1;
      push_n(1);
      bus.i_deq_valid = 1'b1;
      bus.i_push_done = 1'b1; #1;
      n_tests++; if (bus.o_pop !== 1'b1) begin n_fail++; $display("FAIL coin_pop got %0b want 1", bus.o_pop); end
      step();
      bus.i_deq_valid = 1'b0;
      bus.i_push_done = 1'b0; #1;
      n_tests++; if (bus.o_occupancy !== 12'd1) begin n_fail++; $display("FAIL coin_occ got %0d want 1", bus.o_occupancy); end
      repeat (4) step();
   endtask

   task automatic test_saturation();
      apply_reset();
      push_n(OCC_MAX); #1;
      n_tests++; if (bus.o_occupancy !== 12'hFFF || bus.o_ovf !== 1'b0) begin
         n_fail++; $display("FAIL sat_at_max got occ=%0h ovf=%0b want fff/0", bus.o_occupancy, bus.o_ovf);
      end
      push_n(1); #1;
      n_tests++; if (bus.o_occupancy !== 12'hFFF || bus.o_ovf !== 1'b1) begin
         n_fail++; $display("FAIL sat_over got occ=%0h ovf=%0b want fff/1", bus.o_occupancy, bus.o_ovf);
      end
      repeat (3) step();
      bus.i_pair_ready = 1'b1;
      bus.i_rsp_ready  = 1'b1;
      bus.i_deq_valid  = 1'b1; #1;
      n_tests++; if (bus.o_pop !== 1'b1) begin n_fail++; $display("FAIL sat_pop got %0b want 1", bus.o_pop); end
      step();
      bus.i_deq_valid = 1'b0; #1;
      n_tests++; if (bus.o_occupancy !== 12'hFFE || bus.o_ovf !== 1'b1) begin
         n_fail++; $display("FAIL sat_sticky got occ=%0h ovf=%0b want ffe/1", bus.o_occupancy, bus.o_ovf);
      end
      repeat (4) step();
   endtask

   task automatic test_reset_mid_wait();
      apply_reset();
      bus.i_pair_ready = 1'b1;
      bus.i_rsp_ready  = 1'b1;
      push_n(2);
      bus.i_deq_valid = 1'b1; #1;
      n_tests++; if (bus.o_pop !== 1'b1) begin n_fail++; $display("FAIL rstw_pop got %0b want 1", bus.o_pop); end
      step();
      bus.i_deq_valid = 1'b0;
      bus.i_pop_data  = 16'hA5A5; #1;
      arst_n = 1'b0; #1;
      n_tests++; if (bus.o_pop !== 1'b0 || bus.o_rsp_valid !== 1'b0 || bus.o_occupancy !== 12'd0) begin
         n_fail++; $display("FAIL rstw_flush got pop=%0b valid=%0b occ=%0d want 0/0/0", bus.o_pop, bus.o_rsp_valid, bus.o_occupancy);
      end
      step();
      arst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         #1;
         n_tests++; if (bus.o_rsp_valid !== 1'b0 || bus.o_pop !== 1'b0) begin
            n_fail++; $display("FAIL rstw_late_data cycle%0d got valid=%0b pop=%0b want 0/0", i, bus.o_rsp_valid, bus.o_pop);
         end
         step();
      end
      bus.i_pop_data = '0;
   endtask

   // Model: response queue, occupancy count and the cycle at which the pair is free again.
   task automatic test_random();
      int          m_occ      = 0;
      bit          m_ovf      = 1'b0;
      logic [16:0] m_q[$];
      int          cyc        = 0;
      int          busy_until = 0;
      int          cap_cyc    = 0;
      bit          cap_pend   = 1'b0;
      bit          exp_ready, exp_pop, exp_valid;
      int          rsp_pct;
      apply_reset();
      for (int k = 0; k < 2000; k++) begin
         rsp_pct = ((k / 250) % 2 == 1) ? 15 : 80;
         bus.i_deq_valid  = ($urandom_range(0, 99) < 55);
         bus.i_rsp_ready  = ($urandom_range(0, 99) < rsp_pct);
         bus.i_push_done  = ($urandom_range(0, 99) < 40);
         bus.i_pair_ready = ($urandom_range(0, 99) < 85);
         bus.i_pop_data   = 16'($urandom);
         #1;
         exp_ready = (cyc >= busy_until) && bus.i_pair_ready && (m_q.size() < RQD);
         exp_pop   = bus.i_deq_valid && exp_ready && (m_occ != 0);
         exp_valid = (m_q.size() != 0);
         n_tests++; if (bus.o_deq_ready !== exp_ready) begin n_fail++; $display("FAIL rnd_ready c%0d got %0b want %0b", cyc, bus.o_deq_ready, exp_ready); end
         n_tests++; if (bus.o_pop !== exp_pop) begin n_fail++; $display("FAIL rnd_pop c%0d got %0b want %0b", cyc, bus.o_pop, exp_pop); end
         n_tests++; if (bus.o_rsp_valid !== exp_valid) begin n_fail++; $display("FAIL rnd_valid c%0d got %0b want %0b", cyc, bus.o_rsp_valid, exp_valid); end
         if (exp_valid) begin
            n_tests++; if ({bus.o_rsp_empty, bus.o_rsp_data} !== m_q[0]) begin
               n_fail++; $display("FAIL rnd_rsp c%0d got %0b/%0h want %0b/%0h", cyc, bus.o_rsp_empty, bus.o_rsp_data, m_q[0][16], m_q[0][15:0]);
            end
         end
         n_tests++; if (bus.o_occupancy !== OCW'(m_occ) || bus.o_ovf !== m_ovf) begin
            n_fail++; $display("FAIL rnd_occ c%0d got %0d/%0b want %0d/%0b", cyc, bus.o_occupancy, bus.o_ovf, m_occ, m_ovf);
         end
         if (exp_valid && bus.i_rsp_ready) void'(m_q.pop_front());
         if (cap_pend && cyc == cap_cyc) begin
            m_q.push_back({1'b0, bus.i_pop_data});
            cap_pend = 1'b0;
         end
         if (bus.i_deq_valid && exp_ready) begin
            if (m_occ == 0) m_q.push_back({1'b1, 16'hFFFF});
            else begin
               m_occ--;
               busy_until = cyc + POP_LAT + 1;
               cap_cyc    = cyc + POP_LAT;
               cap_pend   = 1'b1;
            end
         end
         if (bus.i_push_done) begin
            if (m_occ == OCC_MAX) m_ovf = 1'b1;
            else                  m_occ++;
         end
         cyc++;
         step();
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic_pop();
      test_empty_req();
      test_backpressure();
      test_pair_stall();
      test_push_pop_coincide();
      test_saturation();
      test_reset_mid_wait();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
